fetch_pc_sequencer: RTL and testbench

//  Owns the fetch PC register and decides the next fetch address each cycle.

---
 rtl/fetch_pc_sequencer_pkg.sv | 24 ++
 rtl/fetch_pc_sequencer_next_pc_mux.sv | 106 ++++++++++
 rtl/fetch_pc_sequencer.sv | 88 ++++++++
 tb/tb_fetch_pc_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared constants and types for the fetch PC sequencer.
// Pure declarations, no logic and no latency.
// No backpressure: nothing here holds state.
package fetch_pc_sequencer_pkg;

  localparam int unsigned       DEFAULT_PC_WIDTH   = 64;
  localparam int unsigned       DEFAULT_ADDR_WIDTH = 64;
  localparam int unsigned       DEFAULT_CNT_WIDTH  = 16;
  localparam logic [63:0]       DEFAULT_RESET_VEC  = 64'h0000_0000_8000_0000;

  // Instructions are 4-byte aligned; any set bit under this mask is misaligned.
  localparam logic [1:0]        INSTR_ALIGN_MASK   = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_EXC  = 2'd2
  } fetch_state_t;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb & INSTR_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_sequencer_next_pc_mux.sv
// Next-PC priority select (trap > BRU > BPU > sequential) with alignment check.
// Purely combinational; results are registered by the parent.
// Honours backpressure via fire: BPU and sequential advance only on fire.
module fetch_pc_sequencer_next_pc_mux
  import fetch_pc_sequencer_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = DEFAULT_PC_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  fetch_state_t          state,
  input  logic                  fire,
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic                  bpu_taken,
  input  logic [ADDR_WIDTH-1:0] bpu_addr,
  input  logic                  bru_miss,
  input  logic [ADDR_WIDTH-1:0] bru_addr,
  input  logic                  trap_redirect,
  input  logic [ADDR_WIDTH-1:0] trap_addr,
  output fetch_state_t          next_state,
  output logic [PC_WIDTH-1:0]   next_pc,
  output logic                  flush,
  output logic                  misalign,
  output logic [ADDR_WIDTH-1:0] misalign_addr,
  output logic                  count_evt
);

  logic [PC_WIDTH-1:0] trap_pc;
  logic [PC_WIDTH-1:0] bru_pc;
  logic [PC_WIDTH-1:0] bpu_pc;
  logic [PC_WIDTH-1:0] trap_pc_aligned;

  // Redirect addresses are truncated or zero-extended to the PC width.
  generate
    if (ADDR_WIDTH >= PC_WIDTH) begin : g_trunc
      assign trap_pc = trap_addr[PC_WIDTH-1:0];
      assign bru_pc  = bru_addr[PC_WIDTH-1:0];
      assign bpu_pc  = bpu_addr[PC_WIDTH-1:0];
    end else begin : g_zext
      assign trap_pc = {{(PC_WIDTH-ADDR_WIDTH){1'b0}}, trap_addr};
      assign bru_pc  = {{(PC_WIDTH-ADDR_WIDTH){1'b0}}, bru_addr};
      assign bpu_pc  = {{(PC_WIDTH-ADDR_WIDTH){1'b0}}, bpu_addr};
    end
  endgenerate

  // Trap targets are forced aligned rather than checked: a trap never faults.
  assign trap_pc_aligned = {trap_pc[PC_WIDTH-1:2], 2'b00};

  // The exception address only matters when misalign is set, so pick by source.
  assign misalign_addr = bru_miss ? bru_addr : bpu_addr;

  // Priority select; lower-priority inputs in the same cycle are dropped.
  always_comb begin
    next_state = state;
    next_pc    = pc;
    flush      = 1'b0;
    misalign   = 1'b0;
    count_evt  = 1'b0;
    unique case (state)
      ST_BOOT: begin
        next_state = ST_RUN;
        if (trap_redirect) begin
          next_pc   = trap_pc_aligned;
          flush     = 1'b1;
          count_evt = 1'b1;
        end
      end
      ST_RUN: begin
        if (trap_redirect) begin
          next_pc   = trap_pc_aligned;
          flush     = 1'b1;
          count_evt = 1'b1;
        end else if (bru_miss) begin
          if (is_aligned(bru_addr[1:0])) begin
            next_pc   = bru_pc;
            flush     = 1'b1;
            count_evt = 1'b1;
          end else begin
            misalign   = 1'b1;
            next_state = ST_EXC;
          end
        end else if (fire && bpu_taken) begin
          if (is_aligned(bpu_addr[1:0])) begin
            next_pc = bpu_pc;
          end else begin
            misalign   = 1'b1;
            next_state = ST_EXC;
          end
        end else if (fire) begin
          next_pc = pc + PC_WIDTH'(4);
        end
      end
      ST_EXC: begin
        if (trap_redirect) begin
          next_pc    = trap_pc_aligned;
          flush      = 1'b1;
          count_evt  = 1'b1;
          next_state = ST_RUN;
        end
      end
      default: begin
        next_state = ST_BOOT;
      end
    endcase
  end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Owns the fetch PC and issues I-cache fetch requests; parks on misaligned redirects.
// Redirect/exception in cycle N is visible on all outputs in cycle N+1.
// fetch_pc_o holds while valid & !ready, except for BRU/trap redirects.
module fetch_pc_sequencer
  import fetch_pc_sequencer_pkg::*;
#(
  parameter int unsigned        PC_WIDTH   = DEFAULT_PC_WIDTH,
  parameter int unsigned        ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_VEC = PC_WIDTH'(DEFAULT_RESET_VEC),
  parameter int unsigned        CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fetch_ready_i,
  output logic                  fetch_valid_o,
  output logic [PC_WIDTH-1:0]   fetch_pc_o,
  input  logic                  bpu_taken_i,
  input  logic [ADDR_WIDTH-1:0] bpu_addr_i,
  input  logic                  bru_miss_i,
  input  logic [ADDR_WIDTH-1:0] bru_addr_i,
  input  logic                  trap_redirect_i,
  input  logic [ADDR_WIDTH-1:0] trap_addr_i,
  output logic                  flush_o,
  output logic                  misalign_exc_o,
  output logic [ADDR_WIDTH-1:0] misalign_addr_o,
  output logic [CNT_WIDTH-1:0]  redirect_cnt_o
);

  fetch_state_t          state_q;
  fetch_state_t          next_state;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [PC_WIDTH-1:0]   next_pc;
  logic                  flush_nxt;
  logic                  misalign_nxt;
  logic [ADDR_WIDTH-1:0] misalign_addr_nxt;
  logic                  count_evt;
  logic                  fire;

  assign fire       = fetch_valid_o & fetch_ready_i;
  assign fetch_pc_o = pc_q;

  fetch_pc_sequencer_next_pc_mux #(
    .PC_WIDTH   (PC_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_next_pc_mux (
    .state         (state_q),
    .fire          (fire),
    .pc            (pc_q),
    .bpu_taken     (bpu_taken_i),
    .bpu_addr      (bpu_addr_i),
    .bru_miss      (bru_miss_i),
    .bru_addr      (bru_addr_i),
    .trap_redirect (trap_redirect_i),
    .trap_addr     (trap_addr_i),
    .next_state    (next_state),
    .next_pc       (next_pc),
    .flush         (flush_nxt),
    .misalign      (misalign_nxt),
    .misalign_addr (misalign_addr_nxt),
    .count_evt     (count_evt)
  );

  // FSM, PC register and registered outputs; valid is a registered decode of the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_BOOT;
      pc_q            <= RESET_VEC;
      fetch_valid_o   <= 1'b0;
      flush_o         <= 1'b0;
      misalign_exc_o  <= 1'b0;
      misalign_addr_o <= '0;
      redirect_cnt_o  <= '0;
    end else begin
      state_q        <= next_state;
      pc_q           <= next_pc;
      fetch_valid_o  <= (next_state == ST_RUN);
      flush_o        <= flush_nxt;
      misalign_exc_o <= misalign_nxt;
      if (misalign_nxt) begin
        misalign_addr_o <= misalign_addr_nxt;
      end
      if (count_evt && !(&redirect_cnt_o)) begin
        redirect_cnt_o <= redirect_cnt_o + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Self-checking bench for fetch_pc_sequencer: directed scenarios plus randomized traffic.
// Outputs are sampled 1 time unit after the rising edge.
// Counter width is reduced so saturation is reachable in a few cycles.
module tb_fetch_pc_sequencer;

  localparam int unsigned CNT_W     = 4;
  localparam logic [63:0] RESET_VEC = 64'h0000_0000_8000_0000;

  logic              clk;
  logic              rst;
  logic              ready;
  logic              valid;
  logic [63:0]       pc;
  logic              bpu_taken;
  logic [63:0]       bpu_addr;
  logic              bru_miss;
  logic [63:0]       bru_addr;
  logic              trap;
  logic [63:0]       trap_addr;
  logic              flush;
  logic              exc;
  logic [63:0]       exc_addr;
  logic [CNT_W-1:0]  cnt;

  int n_tests;
  int n_fail;

  // Reference model: plain description of what the sequencer should show next cycle.
  logic              m_booting;
  logic              m_parked;
  logic              m_valid;
  logic [63:0]       m_pc;
  logic              m_flush;
  logic              m_exc;
  logic [63:0]       m_exc_addr;
  logic [CNT_W-1:0]  m_cnt;

  fetch_pc_sequencer #(
    .PC_WIDTH   (64),
    .ADDR_WIDTH (64),
    .RESET_VEC  (RESET_VEC),
    .CNT_WIDTH  (CNT_W)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .fetch_ready_i   (ready),
    .fetch_valid_o   (valid),
    .fetch_pc_o      (pc),
    .bpu_taken_i     (bpu_taken),
    .bpu_addr_i      (bpu_addr),
    .bru_miss_i      (bru_miss),
    .bru_addr_i      (bru_addr),
    .trap_redirect_i (trap),
    .trap_addr_i     (trap_addr),
    .flush_o         (flush),
    .misalign_exc_o  (exc),
    .misalign_addr_o (exc_addr),
    .redirect_cnt_o  (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_redirect(input logic [63:0] target);
    m_pc    = target;
    m_flush = 1'b1;
    if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
  endtask

  task automatic model_step();
    logic fire;
    fire    = m_valid && ready;
    m_flush = 1'b0;
    m_exc   = 1'b0;
    if (rst) begin
      m_booting  = 1'b1;
      m_parked   = 1'b0;
      m_valid    = 1'b0;
      m_pc       = RESET_VEC;
      m_exc_addr = '0;
      m_cnt      = '0;
    end else if (trap) begin
      model_redirect(trap_addr & ~64'd3);
      m_booting = 1'b0;
      m_parked  = 1'b0;
      m_valid   = 1'b1;
    end else if (m_booting) begin
      m_booting = 1'b0;
      m_valid   = 1'b1;
    end else if (!m_parked) begin
      if (bru_miss) begin
        if (bru_addr % 4 == 0) begin
          model_redirect(bru_addr);
        end else begin
          m_exc = 1'b1; m_exc_addr = bru_addr; m_parked = 1'b1; m_valid = 1'b0;
        end
      end else if (fire && bpu_taken) begin
        if (bpu_addr % 4 == 0) begin
          m_pc = bpu_addr;
        end else begin
          m_exc = 1'b1; m_exc_addr = bpu_addr; m_parked = 1'b1; m_valid = 1'b0;
        end
      end else if (fire) begin
        m_pc = m_pc + 64'd4;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bpu_taken = 1'b0;
    bru_miss  = 1'b0;
    trap      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b1; idle_inputs();
    bpu_addr = '0; bru_addr = '0; trap_addr = '0;
    step(); step();
    rst = 1'b0;
    n_tests++;
    if (valid !== 1'b0 || pc !== RESET_VEC || flush !== 1'b0 || exc !== 1'b0 ||
        exc_addr !== 64'd0 || cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b pc=%h flush=%b exc=%b addr=%h cnt=%h", valid, pc, flush, exc, exc_addr, cnt);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (valid !== 1'b1 || pc !== RESET_VEC + 64'(4 * i)) begin
        n_fail++;
        $display("FAIL boot_seq[%0d]: valid=%b pc=%h want pc=%h", i, valid, pc, RESET_VEC + 64'(4 * i));
      end
    end
  endtask

  task automatic test_bru_redirect();
    step(); step();
    n_tests++;
    if (pc !== 64'h8000_0010) begin
      n_fail++; $display("FAIL seq_pc: got %h want 80000010", pc);
    end
    ready = 1'b0; bru_miss = 1'b1; bru_addr = 64'h8000_0100;
    step();
    bru_miss = 1'b0;
    n_tests++;
    if (pc !== 64'h8000_0100 || flush !== 1'b1 || cnt !== 4'd1 || valid !== 1'b1) begin
      n_fail++; $display("FAIL bru_redirect: pc=%h flush=%b cnt=%0d valid=%b", pc, flush, cnt, valid);
    end
    step();
    n_tests++;
    if (pc !== 64'h8000_0100 || flush !== 1'b0) begin
      n_fail++; $display("FAIL stall_hold: pc=%h flush=%b want 80000100/0", pc, flush);
    end
  endtask

  task automatic test_misalign();
    ready = 1'b1; bpu_taken = 1'b1; bpu_addr = 64'h8000_0202;
    step();
    bpu_taken = 1'b0;
    n_tests++;
    if (exc !== 1'b1 || exc_addr !== 64'h8000_0202 || valid !== 1'b0 || pc !== 64'h8000_0100 || flush !== 1'b0) begin
      n_fail++; $display("FAIL bpu_misalign: exc=%b addr=%h valid=%b pc=%h flush=%b", exc, exc_addr, valid, pc, flush);
    end
    bru_miss = 1'b1; bru_addr = 64'h8000_0500;
    step();
    bru_miss = 1'b0;
    n_tests++;
    if (exc !== 1'b0 || valid !== 1'b0 || cnt !== 4'd1 || pc !== 64'h8000_0100 || exc_addr !== 64'h8000_0202) begin
      n_fail++; $display("FAIL exc_parked: exc=%b valid=%b cnt=%0d pc=%h addr=%h", exc, valid, cnt, pc, exc_addr);
    end
    trap = 1'b1; trap_addr = 64'h8000_0403;
    step();
    trap = 1'b0;
    n_tests++;
    if (pc !== 64'h8000_0400 || valid !== 1'b1 || flush !== 1'b1 || cnt !== 4'd2 || exc !== 1'b0) begin
      n_fail++; $display("FAIL trap_resume: pc=%h valid=%b flush=%b cnt=%0d exc=%b", pc, valid, flush, cnt, exc);
    end
  endtask

  task automatic test_priority();
    ready = 1'b1;
    trap = 1'b1;      trap_addr = 64'h1000;
    bru_miss = 1'b1;  bru_addr  = 64'h2000;
    bpu_taken = 1'b1; bpu_addr  = 64'h3000;
    step();
    idle_inputs();
    n_tests++;
    if (pc !== 64'h1000 || cnt !== 4'd3 || flush !== 1'b1 || exc !== 1'b0) begin
      n_fail++; $display("FAIL priority: pc=%h cnt=%0d flush=%b exc=%b want 1000/3/1/0", pc, cnt, flush, exc);
    end
  endtask

  task automatic test_wrap_and_saturate();
    ready = 1'b1; trap = 1'b1; trap_addr = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    trap = 1'b0;
    step();
    n_tests++;
    if (pc !== 64'd0 || valid !== 1'b1) begin
      n_fail++; $display("FAIL pc_wrap: pc=%h valid=%b want 0/1", pc, valid);
    end
    ready = 1'b0; bru_miss = 1'b1; bru_addr = 64'h40;
    for (int i = 0; i < 14; i++) step();
    bru_miss = 1'b0;
    n_tests++;
    if (cnt !== {CNT_W{1'b1}} || pc !== 64'h40) begin
      n_fail++; $display("FAIL cnt_saturate: cnt=%h pc=%h want f/40", cnt, pc);
    end
  endtask

  task automatic test_reset_in_exc();
    bru_miss = 1'b1; bru_addr = 64'h41;
    step();
    bru_miss = 1'b0;
    n_tests++;
    if (valid !== 1'b0 || exc !== 1'b1 || exc_addr !== 64'h41) begin
      n_fail++; $display("FAIL enter_exc: valid=%b exc=%b addr=%h", valid, exc, exc_addr);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if (valid !== 1'b0 || pc !== RESET_VEC || flush !== 1'b0 || exc !== 1'b0 ||
        exc_addr !== 64'd0 || cnt !== '0) begin
      n_fail++; $display("FAIL reset_in_exc: valid=%b pc=%h flush=%b exc=%b addr=%h cnt=%h", valid, pc, flush, exc, exc_addr, cnt);
    end
    step();
    n_tests++;
    if (valid !== 1'b1 || pc !== RESET_VEC) begin
      n_fail++; $display("FAIL restart: valid=%b pc=%h want 1/%h", valid, pc, RESET_VEC);
    end
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = {(($urandom_range(7) == 0) ? 32'($urandom) : 32'h0), 32'($urandom)};
    if ($urandom_range(3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic test_random();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 500; i++) begin
      rst       = ($urandom_range(127) == 0);
      ready     = ($urandom_range(3) != 0);
      trap      = ($urandom_range(15) == 0);
      bru_miss  = ($urandom_range(7) == 0);
      bpu_taken = ($urandom_range(2) == 0);
      trap_addr = rand_addr();
      bru_addr  = rand_addr();
      bpu_addr  = rand_addr();
      step();
      n_tests++;
      if (valid !== m_valid || pc !== m_pc || flush !== m_flush || exc !== m_exc ||
          exc_addr !== m_exc_addr || cnt !== m_cnt) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%b pc=%h fl=%b ex=%b ea=%h c=%h want v=%b pc=%h fl=%b ex=%b ea=%h c=%h",
                 i, valid, pc, flush, exc, exc_addr, cnt, m_valid, m_pc, m_flush, m_exc, m_exc_addr, m_cnt);
      end
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_booting = 1'b1; m_parked = 1'b0; m_valid = 1'b0; m_pc = RESET_VEC;
    m_flush = 1'b0; m_exc = 1'b0; m_exc_addr = '0; m_cnt = '0;
    test_reset();
    test_bru_redirect();
    test_misalign();
    test_priority();
    test_wrap_and_saturate();
    test_reset_in_exc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
